// File: rtl/seg_scanner.sv
// seg_scanner: time-multiplexed segment display driver with per-slot dead time,
// brightness PWM and frame-aligned double-buffered pattern updates.
module seg_scanner #(
    parameter int NUM_DIGITS     = 4,
    parameter int SEG_W          = 8,
    parameter int DWELL          = 1024,
    parameter int BLANK          = 16,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int DIG_ACTIVE_LOW = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_DIGITS*SEG_W-1:0] seg_data,
    input  logic [NUM_DIGITS-1:0]       digit_en,
    input  logic                        update,
    input  logic [3:0]                  brightness,
    output logic [SEG_W-1:0]            seg_out,
    output logic [NUM_DIGITS-1:0]       dig_out,
    output logic                        frame_start
);
    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int OW = $clog2(DWELL + 1);
    localparam int IW = $clog2(NUM_DIGITS);
    // XOR masks: inactive line levels, also used to apply output polarity
    localparam logic [SEG_W-1:0]      SEG_OFF = (SEG_ACTIVE_LOW != 0) ? '1 : '0;
    localparam logic [NUM_DIGITS-1:0] DIG_OFF = (DIG_ACTIVE_LOW != 0) ? '1 : '0;

    typedef enum logic [1:0] {PH_BLANK, PH_ON, PH_OFF} phase_e;

    logic [CW-1:0]               cnt_q, cnt_d;
    logic [IW-1:0]               idx_q, idx_d;
    logic [NUM_DIGITS*SEG_W-1:0] shadow_seg_q, shadow_seg_d;
    logic [NUM_DIGITS-1:0]       shadow_en_q, shadow_en_d;
    logic                        pending_q, pending_d;
    logic [OW-1:0]               on_len_q, on_len_d;
    logic [SEG_W-1:0]            seg_out_q, seg_out_d;
    logic [NUM_DIGITS-1:0]       dig_out_q, dig_out_d;
    logic                        frame_start_q, frame_start_d;
    logic                        wrap, frame_first, load, lit;
    phase_e                      phase;

    always_comb begin
        wrap          = cnt_q == CW'(DWELL - 1);
        frame_first   = (idx_q == '0) && (cnt_q == '0);
        load          = frame_first && (pending_q || update);
        cnt_d         = wrap ? '0 : cnt_q + CW'(1);
        idx_d         = !wrap ? idx_q : (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + IW'(1);
        pending_d     = load ? 1'b0 : (pending_q || update);
        shadow_seg_d  = load ? seg_data : shadow_seg_q;
        shadow_en_d   = load ? digit_en : shadow_en_q;
        on_len_d      = (cnt_q == '0) ? OW'((32'(DWELL - BLANK) * (32'(brightness) + 32'd1)) >> 4) : on_len_q;
        phase         = (32'(cnt_q) < BLANK) ? PH_BLANK :
                        (32'(cnt_q) < BLANK + 32'(on_len_q)) ? PH_ON : PH_OFF;
        lit           = (phase == PH_ON) && shadow_en_q[idx_q];
        seg_out_d     = lit ? (shadow_seg_q[idx_q*SEG_W +: SEG_W] ^ SEG_OFF) : SEG_OFF;
        dig_out_d     = lit ? ((NUM_DIGITS'(1) << idx_q) ^ DIG_OFF) : DIG_OFF;
        frame_start_d = frame_first;
    end

    // pending resets high so the shadow loads from live inputs on the first edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            idx_q         <= '0;
            shadow_seg_q  <= '0;
            shadow_en_q   <= '0;
            pending_q     <= 1'b1;
            on_len_q      <= '0;
            seg_out_q     <= SEG_OFF;
            dig_out_q     <= DIG_OFF;
            frame_start_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            shadow_seg_q  <= shadow_seg_d;
            shadow_en_q   <= shadow_en_d;
            pending_q     <= pending_d;
            on_len_q      <= on_len_d;
            seg_out_q     <= seg_out_d;
            dig_out_q     <= dig_out_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign seg_out     = seg_out_q;
    assign dig_out     = dig_out_q;
    assign frame_start = frame_start_q;
endmodule

// File: tb/tb_seg_scanner.sv
// tb_seg_scanner: directed frame-by-frame checks of seg_scanner with a
// 2-digit, 8-cycle-dwell configuration.
module tb_seg_scanner;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] seg_data = 16'hA53C;
    logic [1:0]  digit_en = 2'b11;
    logic        update = 1'b0;
    logic [3:0]  brightness = 4'd15;
    logic [7:0]  seg_out;
    logic [1:0]  dig_out;
    logic        frame_start;
    int          checks = 0;
    int          errors = 0;

    seg_scanner #(
        .NUM_DIGITS(2), .SEG_W(8), .DWELL(8), .BLANK(2),
        .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .seg_data(seg_data), .digit_en(digit_en),
        .update(update), .brightness(brightness), .seg_out(seg_out),
        .dig_out(dig_out), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One 16-cycle frame; output sampled at p reflects scan position p of the frame.
    // If upd_at >= 0, new inputs plus a one-cycle update pulse are driven from position upd_at.
    task automatic run_frame(input string name, input int on, input logic [1:0] en,
                             input logic [15:0] pat, input int upd_at,
                             input logic [15:0] nseg, input logic [1:0] nen);
        for (int p = 0; p < 16; p++) begin
            int  d, c;
            logic l;
            @(posedge clk);
            @(negedge clk);
            d = p / 8;
            c = p % 8;
            l = (c >= 2) && (c < 2 + on) && en[d];
            chk($sformatf("%s fs p%0d", name, p), 32'(frame_start), 32'(p == 0));
            chk($sformatf("%s dig p%0d", name, p), 32'(dig_out), l ? 32'(~(2'b01 << d) & 2'b11) : 32'h3);
            chk($sformatf("%s seg p%0d", name, p), 32'(seg_out), l ? 32'(pat[d*8 +: 8]) : 32'h0);
            update = 1'b0;
            if (p == upd_at) begin
                seg_data = nseg;
                digit_en = nen;
                update   = 1'b1;
            end
        end
    endtask

    initial begin
        #12;
        chk("rst seg", 32'(seg_out), 32'h00);
        chk("rst dig", 32'(dig_out), 32'h3);
        chk("rst fs", 32'(frame_start), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        run_frame("full1", 6, 2'b11, 16'hA53C, -1, 16'h0, 2'b00);
        run_frame("full2", 6, 2'b11, 16'hA53C, -1, 16'h0, 2'b00);
        brightness = 4'd7;
        run_frame("b7", 3, 2'b11, 16'hA53C, -1, 16'h0, 2'b00);
        brightness = 4'd0;
        run_frame("b0", 0, 2'b11, 16'hA53C, -1, 16'h0, 2'b00);
        brightness = 4'd15;
        run_frame("updA", 6, 2'b11, 16'hA53C, 10, 16'hFF00, 2'b11);
        run_frame("updB", 6, 2'b11, 16'hFF00, 10, 16'h1234, 2'b01);
        run_frame("en01", 6, 2'b01, 16'h1234, -1, 16'h0, 2'b00);
        for (int i = 0; i < 5; i++) @(posedge clk);
        @(negedge clk);
        chk("pre-rst dig", 32'(dig_out), 32'h2);
        chk("pre-rst seg", 32'(seg_out), 32'h34);
        #2 rst_n = 1'b0;
        #1;
        chk("mid-rst seg", 32'(seg_out), 32'h00);
        chk("mid-rst dig", 32'(dig_out), 32'h3);
        chk("mid-rst fs", 32'(frame_start), 32'h0);
        @(negedge clk);
        chk("held-rst dig", 32'(dig_out), 32'h3);
        rst_n = 1'b1;
        run_frame("post-rst", 6, 2'b01, 16'h1234, -1, 16'h0, 2'b00);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/seg_scanner.md
SEG_SCANNER -- requirements
Module: seg_scanner

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of multiplexed digits (legal 2..8).
REQ-002 SHALL have parameter SEG_W, default 8, segment lines per digit (legal 1..16).
REQ-003 SHALL have parameter DWELL, default 1024, clk cycles per digit slot (legal 4..65536).
REQ-004 SHALL have parameter BLANK, default 16, dead-time cycles at each slot start (legal 1..DWELL-2).
REQ-005 SHALL have parameter SEG_ACTIVE_LOW, default 0; 1 = segment lit when line low.
REQ-006 SHALL have parameter DIG_ACTIVE_LOW, default 1; 1 = digit selected when line low.
REQ-007 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-008 SHALL have port rst_n, input, 1, reset: asynchronous assert, active-low.
REQ-009 SHALL have port seg_data, input, NUM_DIGITS*SEG_W, digit k pattern in bits [k*SEG_W +: SEG_W], 1 = lit.
REQ-010 SHALL have port digit_en, input, NUM_DIGITS, per-digit enable; 0 = digit dark.
REQ-011 SHALL have port update, input, 1, one-cycle request to capture seg_data/digit_en.
REQ-012 SHALL have port brightness, input, 4, duty level 0..15.
REQ-013 SHALL have port seg_out, output, SEG_W, registered segment drive, polarity per SEG_ACTIVE_LOW.
REQ-014 SHALL have port dig_out, output, NUM_DIGITS, registered one-hot digit select, polarity per DIG_ACTIVE_LOW.
REQ-015 SHALL have port frame_start, output, 1, registered one-cycle pulse marking the first cycle of digit 0's slot.

Function
REQ-016 SHALL keep slot counter cnt (0..DWELL-1) and digit index idx (0..NUM_DIGITS-1); cnt increments every cycle; at DWELL-1 it wraps to 0 and idx increments; idx wraps from NUM_DIGITS-1 to 0.
REQ-017 SHALL give a frame period of exactly NUM_DIGITS*DWELL cycles, independent of digit_en and brightness.
REQ-018 SHALL hold a shadow copy of seg_data and digit_en; display always uses the shadow, never the live inputs.
REQ-019 SHALL set a pending flag on any cycle update=1; flag stays set until consumed.
REQ-020 SHALL, on an edge where (idx,cnt)=(0,0) and pending=1 (or update=1 that same cycle), load the shadow from the live inputs and clear pending.
REQ-021 SHALL sample brightness into on_len = ((DWELL-BLANK)*(brightness+1))>>4 on every edge where cnt=0; value held for the slot.
REQ-022 SHALL sequence each slot through three phases: BLANK for cnt<BLANK; ON for BLANK<=cnt<BLANK+on_len; OFF for remaining cnt.
REQ-023 SHALL drive, in BLANK and OFF, all dig_out and all seg_out lines inactive.
REQ-024 SHALL drive, in ON with shadow enable bit idx=1, dig_out active only on bit idx and seg_out = shadow pattern idx (inverted if SEG_ACTIVE_LOW).
REQ-025 SHALL treat ON with shadow enable bit idx=0 as OFF for the whole slot.
REQ-026 SHALL register seg_out, dig_out and frame_start one cycle after the (idx,cnt) state producing them; never two digits active in the same cycle.
REQ-027 SHALL, at brightness=15, give on_len=DWELL-BLANK (no OFF phase); at on_len=0, keep the slot dark.

Reset
REQ-028 SHALL, while rst_n=0, force immediately: seg_out and dig_out all inactive; frame_start=0; cnt=0; idx=0; shadow data and enables=0; pending=1.
REQ-029 SHALL, on rst_n rising, load the shadow at the first clk edge; frame_start=1 in the cycle after it.
REQ-030 SHALL, on rst_n asserted mid-slot, blank outputs at once with no further ON cycles until a new frame starts.

Verification
REQ-031 SHALL cover, with NUM_DIGITS=2, SEG_W=8, DWELL=8, BLANK=2, DIG_ACTIVE_LOW=1, SEG_ACTIVE_LOW=0:
- seg_data=16'hA53C, digit_en=2'b11, brightness=15, reset released -> per 16-cycle frame: 2 cycles dig_out=2'b11/seg_out=8'h00, 6 cycles dig_out=2'b10/seg_out=8'h3C, 2 blank, 6 cycles dig_out=2'b01/seg_out=8'hA5; frame_start every 16 cycles.
- brightness=7 -> on_len=3: each slot 2 blank, 3 lit, 3 dark; brightness=0 -> on_len=0, display fully dark, frame period still 16.
- seg_data changed to 16'hFF00 plus update pulse during digit 1 slot -> digit 1 keeps 8'hA5 to end of frame; new values from next frame_start.
- digit_en=2'b01 with update -> digit 1 slot fully dark, dig_out never 2'b01, frame period 16.
- rst_n low during digit 0 ON -> same cycle seg_out=8'h00, dig_out=2'b11; after release, old pattern reloads from inputs at first edge.
